// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - op codes, FSM states and helpers for the sequential ALU
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_comb.sv
// rtl/seq_alu_comb.sv - single-cycle ALU ops with ADD/SUB carry and overflow
module seq_alu_comb
    import seq_alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] rd,
    output logic            carry,
    output logic            overflow
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic [SHAMT_W-1:0] shamt;
    logic               is_sub;
    logic [XLEN-1:0]    b_eff;
    logic [XLEN:0]      sum;
    logic               carry_into_msb;

    // SUB shares the adder: a + ~b + 1, so carry out of the MSB means no borrow
    assign shamt          = b[SHAMT_W-1:0];
    assign is_sub         = (op == OP_SUB);
    assign b_eff          = is_sub ? ~b : b;
    assign sum            = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
    assign carry_into_msb = a[XLEN-1] ^ b_eff[XLEN-1] ^ sum[XLEN-1];

    // Result select; flags are only meaningful for ADD/SUB, illegal codes give zero
    always_comb begin
        rd       = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                rd       = sum[XLEN-1:0];
                carry    = sum[XLEN];
                overflow = carry_into_msb ^ sum[XLEN];
            end
            OP_AND:  rd = a & b;
            OP_OR:   rd = a | b;
            OP_XOR:  rd = a ^ b;
            OP_SLL:  rd = a << shamt;
            OP_SRL:  rd = a >> shamt;
            OP_SRA:  rd = $signed(a) >>> shamt;
            OP_SLT:  rd = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: rd = {{(XLEN-1){1'b0}}, (a < b)};
            default: rd = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked execute ALU with iterative unsigned MUL/DIV
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            zero_flag,
    output logic            carry_flag,
    output logic            overflow_flag,
    output logic            busy
);

    state_t              state, state_d;
    logic [SHAMT_W-1:0]  cnt;
    logic [3:0]          op_q;
    logic [XLEN-1:0]     acc_hi, acc_lo, opb;
    logic [XLEN-1:0]     acc_hi_d, acc_lo_d;
    logic [XLEN:0]       mul_sum, div_sh, div_diff;
    logic [XLEN-1:0]     comb_rd, mc_rd;
    logic                comb_carry, comb_ovf;
    logic                accept, last_step;

    seq_alu_comb #(.XLEN(XLEN)) u_comb (
        .op       (op),
        .a        (rs1),
        .b        (rs2),
        .rd       (comb_rd),
        .carry    (comb_carry),
        .overflow (comb_ovf)
    );

    assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != S_IDLE);
    assign last_step = (cnt == SHAMT_W'(XLEN - 1));
    assign mc_rd     = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? acc_lo : acc_hi;

    // One shift-add (MUL) or restoring-subtract (DIV) step on {acc_hi, acc_lo}
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : {XLEN{1'b0}})};
        div_sh   = {acc_hi, acc_lo[XLEN-1]};
        div_diff = div_sh - {1'b0, opb};
        acc_hi_d = acc_hi;
        acc_lo_d = acc_lo;
        if (state == S_MUL) begin
            acc_hi_d = mul_sum[XLEN:1];
            acc_lo_d = {mul_sum[0], acc_lo[XLEN-1:1]};
        end else if (state == S_DIV) begin
            if (!div_diff[XLEN]) begin
                acc_hi_d = div_diff[XLEN-1:0];
                acc_lo_d = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                acc_hi_d = div_sh[XLEN-1:0];
                acc_lo_d = {acc_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (accept && is_multicycle(op)) begin
                    state_d = ((op == OP_MUL) || (op == OP_MULHU)) ? S_MUL : S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_valid && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, iteration datapath and output registers; DONE's first cycle writes the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            op_q          <= 4'd0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            opb           <= '0;
            out_valid     <= 1'b0;
            rd            <= '0;
            zero_flag     <= 1'b1;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            state  <= state_d;
            acc_hi <= acc_hi_d;
            acc_lo <= acc_lo_d;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_multicycle(op)) begin
                            op_q      <= op;
                            cnt       <= '0;
                            acc_hi    <= '0;
                            acc_lo    <= rs1;
                            opb       <= rs2;
                            out_valid <= 1'b0;
                        end else begin
                            rd            <= comb_rd;
                            zero_flag     <= (comb_rd == '0);
                            carry_flag    <= comb_carry;
                            overflow_flag <= comb_ovf;
                            out_valid     <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_MUL, S_DIV: begin
                    cnt <= cnt + SHAMT_W'(1);
                end
                S_DONE: begin
                    if (!out_valid) begin
                        rd            <= mc_rd;
                        zero_flag     <= (mc_rd == '0);
                        carry_flag    <= 1'b0;
                        overflow_flag <= 1'b0;
                        out_valid     <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
